// File: rtl/tank_pkg.sv
// Shared definitions for the tank AI: HID key codes, FSM state encoding and
// movement directions, plus helpers that map directions to keys.
package tank_pkg;

  localparam logic [7:0] KeyNone  = 8'h00;
  localparam logic [7:0] KeyUp    = 8'h1A;
  localparam logic [7:0] KeyDown  = 8'h16;
  localparam logic [7:0] KeyLeft  = 8'h04;
  localparam logic [7:0] KeyRight = 8'h07;
  localparam logic [7:0] KeyFire  = 8'h2C;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StChase   = 3'd1,
    StAim     = 3'd2,
    StFire    = 3'd3,
    StBackoff = 3'd4
  } ai_state_t;

  typedef enum logic [2:0] {
    DirUp    = 3'd1,
    DirRight = 3'd2,
    DirLeft  = 3'd3,
    DirDown  = 3'd4
  } dir_t;

  function automatic logic [7:0] dir_key(dir_t d);
    case (d)
      DirUp:    dir_key = KeyUp;
      DirRight: dir_key = KeyRight;
      DirLeft:  dir_key = KeyLeft;
      DirDown:  dir_key = KeyDown;
      default:  dir_key = KeyNone;
    endcase
  endfunction

  function automatic dir_t dir_opposite(dir_t d);
    case (d)
      DirUp:    dir_opposite = DirDown;
      DirRight: dir_opposite = DirLeft;
      DirLeft:  dir_opposite = DirRight;
      DirDown:  dir_opposite = DirUp;
      default:  dir_opposite = DirDown;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick.sv
// Brings an asynchronous frame strobe into the clk domain and turns each of
// its rising edges into a single-cycle tick.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   frame_clk : asynchronous frame strobe
//   tick      : one-clk pulse per frame_clk rising edge (2-3 clks of latency)
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/tank_ai.sv
// Frame-driven opponent AI: chases the target, aligns on one axis, fires when
// the gun is cooled and no bullet is in flight, and reverses after wall hits.
//   Clk, Reset         : system clock, asynchronous active-high reset
//   frame_clk          : asynchronous frame strobe
//   enable             : AI drives the tank when high
//   self_X/Y, target_X/Y : top-left positions of own and opponent tank
//   collides           : own tank overlaps a wall this cycle
//   hit                : own bullet state, 2'b00 means no bullet on screen
//   keycode            : key driven into the tank controller
//   ai_state           : current FSM state for debug
module tank_ai
  import tank_pkg::*;
#(
  parameter int unsigned ALIGN_TOL      = 4,
  parameter int unsigned FIRE_COOLDOWN  = 30,
  parameter int unsigned BACKOFF_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic [9:0] self_X,
  input  logic [9:0] self_Y,
  input  logic [9:0] target_X,
  input  logic [9:0] target_Y,
  input  logic       collides,
  input  logic [1:0] hit,
  output logic [7:0] keycode,
  output logic [2:0] ai_state
);

  localparam int unsigned BoW = $clog2(BACKOFF_FRAMES + 1);
  localparam logic [9:0]     Tol      = 10'(ALIGN_TOL);
  localparam logic [5:0]     CoolLoad = 6'(FIRE_COOLDOWN);
  // Entry tick already drives the reverse key, so the counter covers the rest.
  localparam logic [BoW-1:0] BoffLoad = BoW'(BACKOFF_FRAMES - 1);

  logic tick;

  frame_tick u_frame_tick (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  ai_state_t      state_q, state_d;
  logic [7:0]     key_q, key_d;
  logic [5:0]     cool_q, cool_d;
  logic [BoW-1:0] boff_q, boff_d;
  logic           collide_q, collide_d;
  logic           swap_q, swap_d;
  dir_t           last_q, last_d;

  // 11-bit differences cannot wrap for 10-bit coordinates.
  logic [10:0] dx, dy, ndx, ndy;
  logic [9:0]  adx, ady;
  logic        aligned, use_x, collide_now;
  dir_t        move_dir, aim_dir;

  assign dx  = {1'b0, target_X} - {1'b0, self_X};
  assign dy  = {1'b0, target_Y} - {1'b0, self_Y};
  assign ndx = -dx;
  assign ndy = -dy;
  assign adx = dx[10] ? ndx[9:0] : dx[9:0];
  assign ady = dy[10] ? ndy[9:0] : dy[9:0];

  assign aligned     = (adx <= Tol) || (ady <= Tol);
  assign use_x       = (adx > ady) || ((adx == ady) && !swap_q);
  assign move_dir    = use_x ? (dx[10] ? DirLeft : DirRight) : (dy[10] ? DirUp : DirDown);
  assign aim_dir     = (adx <= Tol) ? (dy[10] ? DirUp : DirDown)
                                    : (dx[10] ? DirLeft : DirRight);
  // A collision in the same cycle as the tick still counts for that tick.
  assign collide_now = collide_q | collides;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    cool_d    = cool_q;
    boff_d    = boff_q;
    collide_d = collide_q | collides;
    swap_d    = swap_q;
    last_d    = last_q;

    if (tick) begin
      collide_d = 1'b0;
      cool_d    = (cool_q == 6'd0) ? 6'd0 : cool_q - 6'd1;
      case (state_q)
        StIdle: begin
          key_d = KeyNone;
          if (enable) state_d = StChase;
        end
        StChase: begin
          if (collide_now) begin
            state_d = StBackoff;
            key_d   = dir_key(dir_opposite(last_q));
            boff_d  = BoffLoad;
          end else if (aligned) begin
            state_d = StAim;
            key_d   = KeyNone;
          end else begin
            key_d  = dir_key(move_dir);
            last_d = move_dir;
          end
        end
        StAim: begin
          if (collide_now) begin
            state_d = StBackoff;
            key_d   = dir_key(dir_opposite(last_q));
            boff_d  = BoffLoad;
          end else begin
            key_d  = dir_key(aim_dir);
            last_d = aim_dir;
            if (!aligned)                               state_d = StChase;
            else if ((cool_q == 6'd0) && (hit == 2'b00)) state_d = StFire;
          end
        end
        StFire: begin
          key_d   = KeyFire;
          cool_d  = CoolLoad;
          swap_d  = 1'b0;
          state_d = StChase;
        end
        StBackoff: begin
          if (boff_q != '0) begin
            key_d  = dir_key(dir_opposite(last_q));
            boff_d = boff_q - BoW'(1);
          end else begin
            key_d   = KeyNone;
            swap_d  = ~swap_q;
            state_d = StChase;
          end
        end
        default: begin
          key_d   = KeyNone;
          state_d = StIdle;
        end
      endcase
    end

    // Disable wins immediately, independent of the frame tick.
    if (!enable) begin
      state_d = StIdle;
      key_d   = KeyNone;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      key_q     <= KeyNone;
      cool_q    <= 6'd0;
      boff_q    <= '0;
      collide_q <= 1'b0;
      swap_q    <= 1'b0;
      last_q    <= DirUp;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      cool_q    <= cool_d;
      boff_q    <= boff_d;
      collide_q <= collide_d;
      swap_q    <= swap_d;
      last_q    <= last_d;
    end
  end

  assign keycode  = key_q;
  assign ai_state = state_q;

endmodule

// File: tb/tb_tank_ai.sv
module tb_tank_ai;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       enable = 1'b0;
  logic [9:0] self_X = '0, self_Y = '0, target_X = '0, target_Y = '0;
  logic       collides = 1'b0;
  logic [1:0] hit = 2'b00;
  logic [7:0] keycode;
  logic [2:0] ai_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] key_pre;

  tank_ai dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .enable    (enable),
    .self_X    (self_X),
    .self_Y    (self_Y),
    .target_X  (target_X),
    .target_Y  (target_Y),
    .collides  (collides),
    .hit       (hit),
    .keycode   (keycode),
    .ai_state  (ai_state)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] key, input logic [2:0] st);
    check({tag, "_key"}, keycode, key);
    check({tag, "_state"}, {5'd0, ai_state}, {5'd0, st});
  endtask

  // One frame: tick appears two clks after the rise; outputs move one clk later.
  task automatic frame();
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1 key_pre = keycode;
    @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic pulse_collide();
    @(negedge Clk) collides = 1'b1;
    @(negedge Clk) collides = 1'b0;
  endtask

  task automatic set_pos(input int sx, input int sy, input int tx, input int ty);
    self_X = 10'(sx); self_Y = 10'(sy); target_X = 10'(tx); target_Y = 10'(ty);
  endtask

  initial begin
    // Reset state
    #5;
    expect_out("reset", 8'h00, 3'd0);
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;

    // Chase toward a target mostly to the right
    set_pos(100, 100, 300, 120);
    enable = 1'b1;
    frame();
    expect_out("chase_entry", 8'h00, 3'd1);
    frame();
    check("key_before_update", key_pre, 8'h00);
    expect_out("chase_right", 8'h07, 3'd1);
    set_pos(100, 100, 20, 110);
    frame();
    expect_out("chase_left", 8'h04, 3'd1);
    set_pos(100, 100, 110, 300);
    frame();
    expect_out("chase_down", 8'h16, 3'd1);
    set_pos(100, 100, 110, 10);
    frame();
    expect_out("chase_up", 8'h1A, 3'd1);
    set_pos(100, 100, 300, 300);
    frame();
    expect_out("chase_tie_x", 8'h07, 3'd1);

    // Wall hit: reverse for 16 frames, later collisions ignored, then swap tie axis
    pulse_collide();
    frame();
    expect_out("backoff_entry", 8'h04, 3'd4);
    for (int i = 1; i < 16; i++) begin
      if (i == 5) pulse_collide();
      frame();
      expect_out("backoff_hold", 8'h04, 3'd4);
    end
    frame();
    expect_out("backoff_exit", 8'h00, 3'd1);
    frame();
    expect_out("chase_tie_y", 8'h16, 3'd1);

    // Enable drop without a tick
    @(negedge Clk) enable = 1'b0;
    @(posedge Clk);
    #1 expect_out("disable", 8'h00, 3'd0);
    @(negedge Clk) enable = 1'b1;

    // Aligned on X: aim down, fire once, cooldown of 30 frames
    set_pos(300, 100, 302, 400);
    frame();
    expect_out("fire_idle_exit", 8'h00, 3'd1);
    frame();
    expect_out("fire_to_aim", 8'h00, 3'd2);
    frame();
    expect_out("aim_down", 8'h16, 3'd3);
    frame();
    expect_out("fire_key", 8'h2C, 3'd1);
    frame();
    expect_out("cool_chase", 8'h00, 3'd2);
    for (int i = 2; i <= 30; i++) begin
      frame();
      expect_out("cool_aim", 8'h16, 3'd2);
    end
    frame();
    expect_out("cool_done", 8'h16, 3'd3);
    frame();
    expect_out("fire_again", 8'h2C, 3'd1);

    // Bullet in flight: never fire even after cooldown expires
    hit = 2'b01;
    frame();
    expect_out("hit_to_aim", 8'h00, 3'd2);
    for (int i = 2; i <= 40; i++) begin
      frame();
      expect_out("hit_hold", 8'h16, 3'd2);
    end

    // Collision from AIM reverses the last aim key, then async reset mid-backoff
    pulse_collide();
    frame();
    expect_out("aim_backoff", 8'h1A, 3'd4);
    frame();
    @(negedge Clk);
    #3 Reset = 1'b1;
    #1 expect_out("async_reset", 8'h00, 3'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    hit = 2'b00;
    frame();
    expect_out("post_reset_chase", 8'h00, 3'd1);
    frame();
    expect_out("post_reset_aim", 8'h00, 3'd2);
    frame();
    expect_out("post_reset_arm", 8'h16, 3'd3);
    frame();
    expect_out("post_reset_fire", 8'h2C, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tank_ai.md
TANK_AI -- requirements
Module: tank_ai

Interface
REQ-001 Parameter ALIGN_TOL, default 4: pixel tolerance for treating the tank as aligned with the target on one axis.
REQ-002 Parameter FIRE_COOLDOWN, default 30: frames between shots.
REQ-003 Parameter BACKOFF_FRAMES, default 16: frames spent reversing after a wall contact.
REQ-004 One clock; reset is asynchronous and active-high. Ports are listed below.
REQ-005 Clk  in  1  50 MHz system clock.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 frame_clk  in  1  frame strobe, ~60 Hz, asynchronous to Clk.
REQ-008 enable  in  1  AI drives the tank when high.
REQ-009 self_X, self_Y  in  10 each  top-left position of the controlled tank.
REQ-010 target_X, target_Y  in  10 each  top-left position of the opponent tank.
REQ-011 collides  in  1  per-pixel overlap of the controlled tank with a wall.
REQ-012 hit  in  2  bullet state of the controlled tank; 00 means no bullet on screen.
REQ-013 keycode  out  8  HID-style key driven into the tank controller.
REQ-014 ai_state  out  3  current FSM state, for debug.

Function
REQ-015 frame_clk shall pass a 2-flop synchronizer, then rising-edge detection, giving a one-Clk "tick".
REQ-016 All state, keycode and counter updates shall occur only on tick, except where REQ-026 says otherwise.
- keycode shall change exactly 1 Clk after tick.
REQ-017 Key encodings shall be: up 0x1A, down 0x16, left 0x04, right 0x07, fire 0x2C, none 0x00.
REQ-018 dx = target_X − self_X and dy = target_Y − self_Y shall be computed as 11-bit signed values.
- |dx| and |dy| shall be 10-bit unsigned.
- No wrap-around is permitted.
REQ-019 FSM states shall be IDLE=0, CHASE=1, AIM=2, FIRE=3, BACKOFF=4.
REQ-020 IDLE: keycode 0x00; on tick with enable=1, go to CHASE.
REQ-021 CHASE: if |dx|≤ALIGN_TOL or |dy|≤ALIGN_TOL, go to AIM. Otherwise drive a move key along the axis with the larger distance.
- Tie goes to X, unless axis_swap=1, in which case Y is chosen.
- Sign of dx/dy selects right/left or down/up.
REQ-022 AIM: drive the direction key facing the target on the aligned axis.
- If |dx|≤ALIGN_TOL, face up/down by the sign of dy; else face left/right by the sign of dx.
- dx=0 or dy=0 counts as non-negative.
- Next tick with still aligned, cooldown=0 and hit=00: go to FIRE.
- Still aligned otherwise: remain in AIM.
- No longer aligned: go to CHASE.
REQ-023 FIRE: keycode 0x2C for exactly one frame; load cooldown=FIRE_COOLDOWN; clear axis_swap; return to CHASE.
REQ-024 A sticky collide_seen flag shall set on any Clk with collides=1 and clear on tick after being sampled.
- In CHASE or AIM, a tick with collide_seen=1 shall go to BACKOFF.
- This takes priority over every other transition.
REQ-025 BACKOFF: drive the opposite of the last movement key for BACKOFF_FRAMES ticks (frame counter); then toggle axis_swap and go to CHASE.
- Collisions during BACKOFF shall be ignored.
REQ-026 enable=0 shall force IDLE and keycode 0x00 on the next Clk, regardless of tick.
REQ-027 The cooldown counter shall be 6-bit, decrement on each tick, and saturate at 0.
- It shall decrement in every state, including IDLE.
REQ-028 Simultaneous tick and collides on the same Clk shall count toward that tick's decision.

Reset
REQ-029 Reset shall asynchronously clear the following: state=IDLE, keycode=0x00, ai_state=0, cooldown=0, backoff counter=0, collide_seen=0, axis_swap=0, last movement key=0x1A, synchronizer flops=0.
REQ-030 Reset asserted mid-BACKOFF or mid-FIRE shall abandon the operation; no fire key shall appear after reset deasserts until a full AIM→FIRE sequence occurs.

Structure
REQ-031 Package tank_pkg shall hold the keycode constants, the ai_state_t enum and the dir_t enum (up=1, right=2, left=3, down=4).
REQ-032 Sub-module frame_tick shall hold the synchronizer and edge detector.
- It shall be reusable by other frame-driven blocks.
REQ-033 The remainder (FSM, counters, distance logic) shall live in tank_ai.

Verification
REQ-034 Stimulus: self=(100,100), target=(300,120), enable=1. Response: keycode 0x07 one Clk after the second tick.
REQ-035 Stimulus: self=(300,100), target=(302,400), cooldown=0, hit=00. Response: AIM drives 0x16, the next tick drives 0x2C for one frame, and no further 0x2C appears within 30 ticks.
REQ-036 Stimulus: as REQ-035 but hit=01 held. Response: remains in AIM with 0x16; 0x2C never appears.
REQ-037 Stimulus: CHASE driving 0x07, one-Clk collides pulse mid-frame. Response: next tick → BACKOFF with 0x04 for 16 ticks, then CHASE with axis_swap=1.
REQ-038 Stimulus: enable dropped mid-CHASE with no tick. Response: keycode 0x00 and ai_state=0 the next Clk.
REQ-039 Stimulus: Reset asserted asynchronously during BACKOFF. Response: all outputs zero immediately, without waiting for a Clk edge.
